// File: rtl/fifo_rr_ctrl_pkg.sv
// Shared types and constants for the round-robin fifo write scheduler.
package fifo_ctrl_pkg;

   localparam int unsigned STALL_W = 16;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/fifo_rr_ctrl_rr_pick.sv
// Combinational round-robin search: first requester after last_grant, wrapping modulo NREQ.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [IW-1:0]   winner,
   output logic            any
);

   logic [IW-1:0] idx;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = IW'((32'(last_grant) + k) % NREQ);
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Round-robin write scheduler with optional burst lock, plus valid/ready read adapter, for a shared fifo.
module fifo_rr_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BURST = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   input  logic                    out_ready,
   output logic                    fifo_push,
   output logic                    fifo_pop,
   output logic [WIDTH-1:0]        fifo_datain,
   input  logic                    fifo_full,
   input  logic                    fifo_empty,
   input  logic [WIDTH-1:0]        fifo_dataout,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    locked,
   output logic [15:0]             stall_cnt
);

   localparam int unsigned  IW       = $clog2(NREQ);
   localparam int unsigned  BW       = $clog2(BURST + 1);
   localparam logic [BW-1:0] BURST_L = BW'(BURST);
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

   if (NREQ < 2 || NREQ > 8 || BURST < 1 || DEPTH < 1) begin : g_bad_param
      $error("fifo_rr_ctrl: unsupported parameter set");
   end

   state_e             state_q, state_d;
   logic [IW-1:0]      last_grant_q, last_grant_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      grant_id_q, grant_id_d;
   logic [BW-1:0]      beat_q, beat_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [IW-1:0]      rr_winner;
   logic               rr_any;
   logic               push;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .winner     (rr_winner),
      .any        (rr_any)
   );

   // Grants depend only on registered state and fifo_full, so a same-cycle pop never frees a slot.
   always_comb begin
      req_ready = '0;
      if (!rst) begin
         if (state_q == IDLE) begin
            if (rr_any && !fifo_full) req_ready[rr_winner] = 1'b1;
         end else if (req_valid[owner_q] && !fifo_full) begin
            req_ready[owner_q] = 1'b1;
         end
      end
   end

   assign push = |(req_valid & req_ready);

   always_comb begin
      fifo_datain = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_ready[i]) fifo_datain = req_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      grant_id_d   = grant_id_q;
      beat_d       = beat_q;
      stall_d      = stall_q;
      if (|req_valid && !push && stall_q != '1) stall_d = stall_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (push) begin
               last_grant_d = rr_winner;
               grant_id_d   = rr_winner;
               if (BURST > 1) begin
                  state_d = LOCKED;
                  owner_d = rr_winner;
                  beat_d  = BW'(1);
               end
            end
         end
         LOCKED: begin
            if (!req_valid[owner_q]) begin
               state_d = IDLE;
               beat_d  = '0;
            end else if (push) begin
               beat_d = beat_q + 1'b1;
               if (beat_d == BURST_L) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_RST;
         owner_q      <= '0;
         grant_id_q   <= '0;
         beat_q       <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         grant_id_q   <= grant_id_d;
         beat_q       <= beat_d;
         stall_q      <= stall_d;
      end
   end

   assign fifo_push = push;
   assign out_valid = ~fifo_empty & ~rst;
   assign out_data  = fifo_dataout;
   assign fifo_pop  = out_valid & out_ready;
   assign grant_id  = grant_id_q;
   assign locked    = (state_q == LOCKED);
   assign stall_cnt = stall_q;

   a_no_push_full: assert property (@(posedge clk) !(fifo_push && fifo_full));
   a_no_pop_empty: assert property (@(posedge clk) !(fifo_pop && fifo_empty));
   a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
